// File: rtl/data_collector.sv
// Packs NUM_BYTES strobed elements into one word (first byte in the MSBs) and holds it
// under a valid/ready handshake. Define DATA_COLLECTOR_OVERRUN_EN for the sticky overrun flag.
module data_collector #(
  parameter int DATA_W    = 8,
  parameter int NUM_BYTES = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          clear,
  input  logic                          out_ready,
  output logic [DATA_W*NUM_BYTES-1:0]   data_out,
  output logic                          out_valid,
  output logic [2:0]                    count,
  output logic                          overrun
);

  localparam int         WORD_W = DATA_W * NUM_BYTES;
  localparam logic [2:0] LAST   = 3'(NUM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [2:0]          count_q, count_d;
  logic [2:0]          count_inc;
  logic [WORD_W-1:0]   din_ext;

  assign count_inc = count_q + 3'd1;
  assign din_ext   = WORD_W'(data_in);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    if (clear) begin
      state_d = IDLE;
      data_d  = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE, COLLECT: begin
          if (enable) begin
            data_d  = (data_q << DATA_W) | din_ext;
            count_d = count_inc;
            state_d = (count_inc == LAST) ? HOLD : COLLECT;
          end
        end
        HOLD: begin
          if (out_ready) begin
            // A strobe coinciding with the handshake starts the next word without a bubble.
            if (enable) begin
              data_d  = din_ext;
              count_d = 3'd1;
              state_d = (LAST == 3'd1) ? HOLD : COLLECT;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign data_out  = data_q;
  assign count     = count_q;
  assign out_valid = (state_q == HOLD);

`ifdef DATA_COLLECTOR_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (clear)
      overrun_d = 1'b0;
    else if ((state_q == HOLD) && !out_ready && enable)
      overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule
